// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath defaults and ALU operation codes.
package proc_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 4;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOR   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;

endpackage

// File: rtl/mux2.sv
// Generic 2:1 multiplexer: sel=0 selects in0, sel=1 selects in1.
module mux2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // Purely combinational select.
    always_comb begin
        out = sel ? in1 : in0;
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage slice: B-operand select, ALU, writeback select and the
// registered writeback bundle / flags feeding the register file.
module alu_exec_stage
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W  = proc_pkg::DATA_W,
    parameter int unsigned RADDR_W = proc_pkg::RADDR_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [DATA_W-1:0]  rs1_data,
    input  logic [DATA_W-1:0]  rs2_data,
    input  logic [DATA_W-1:0]  imm_ext,
    input  logic [3:0]         alu_control,
    input  logic               sel_aluB,
    input  logic               sel_wdata,
    input  logic               sel_wreg,
    input  logic [RADDR_W-1:0] rd_ar,
    input  logic [RADDR_W-1:0] rd_ti,
    input  logic               reg_write,
    output logic [DATA_W-1:0]  alu_result,
    output logic               alu_cout,
    output logic [RADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]  write_data,
    output logic [RADDR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]  wb_data,
    output logic               wb_we,
    output logic               flag_c,
    output logic               flag_z
);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [4:0]        shamt;
    logic              zero;

    assign op_a = rs1_data;

    mux2 #(.WIDTH(DATA_W)) u_mux_aluB (
        .in0 (rs2_data),
        .in1 (imm_ext),
        .sel (sel_aluB),
        .out (op_b)
    );

    mux2 #(.WIDTH(DATA_W)) u_mux_wdata (
        .in0 (alu_result),
        .in1 (imm_ext),
        .sel (sel_wdata),
        .out (write_data)
    );

    mux2 #(.WIDTH(RADDR_W)) u_mux_wreg (
        .in0 (rd_ar),
        .in1 (rd_ti),
        .sel (sel_wreg),
        .out (write_reg)
    );

    // Adder and subtractor widened by one bit so the carry falls out as the MSB.
    always_comb begin
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        diff_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
        shamt    = op_b[4:0];
    end

    // ALU operation decode; unused codes yield zero with no carry.
    always_comb begin
        alu_result = '0;
        alu_cout   = 1'b0;
        unique case (alu_control)
            ALU_ADD: begin
                alu_result = sum_ext[DATA_W-1:0];
                alu_cout   = sum_ext[DATA_W];
            end
            ALU_SUB: begin
                alu_result = diff_ext[DATA_W-1:0];
                alu_cout   = diff_ext[DATA_W];
            end
            ALU_AND:   alu_result = op_a & op_b;
            ALU_OR:    alu_result = op_a | op_b;
            ALU_XOR:   alu_result = op_a ^ op_b;
            ALU_NOR:   alu_result = ~(op_a | op_b);
            ALU_SLL:   alu_result = op_a << shamt;
            ALU_SRL:   alu_result = op_a >> shamt;
            ALU_SRA:   alu_result = $signed(op_a) >>> shamt;
            ALU_SLT:   alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            ALU_PASSB: alu_result = op_b;
            default:   alu_result = '0;
        endcase
    end

    // Zero flag source.
    always_comb begin
        zero = (alu_result == '0);
    end

    // Writeback bundle and flag register; reset clears everything immediately.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wb_reg  <= '0;
            wb_data <= '0;
            wb_we   <= 1'b0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            wb_reg  <= write_reg;
            wb_data <= write_data;
            wb_we   <= reg_write;
            flag_c  <= alu_cout;
            flag_z  <= zero;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage with a queue of expected writebacks.
module tb_alu_exec_stage;

    logic        CLK;
    logic        RESET;
    logic [31:0] rs1_data, rs2_data, imm_ext;
    logic [3:0]  alu_control;
    logic        sel_aluB, sel_wdata, sel_wreg;
    logic [3:0]  rd_ar, rd_ti;
    logic        reg_write;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic [3:0]  write_reg;
    logic [31:0] write_data;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_we, flag_c, flag_z;

    typedef struct {
        logic [3:0]  wreg;
        logic [31:0] wdata;
        logic        we;
        logic        c;
        logic        z;
    } wb_exp_t;

    wb_exp_t exp_q[$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_exec_stage #(.DATA_W(32), .RADDR_W(4)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm_ext     (imm_ext),
        .alu_control (alu_control),
        .sel_aluB    (sel_aluB),
        .sel_wdata   (sel_wdata),
        .sel_wreg    (sel_wreg),
        .rd_ar       (rd_ar),
        .rd_ti       (rd_ti),
        .reg_write   (reg_write),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .wb_we       (wb_we),
        .flag_c      (flag_c),
        .flag_z      (flag_z)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Reference ALU written independently of the RTL structure.
    task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           output logic [31:0] res, output logic cy);
        logic [63:0] sx;
        int unsigned sh;
        sh  = b % 32;
        res = 32'h0;
        cy  = 1'b0;
        case (op)
            4'd0: begin res = a + b; cy = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF; end
            4'd1: begin res = a - b; cy = (a >= b); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~(a | b);
            4'd6: res = a << sh;
            4'd7: res = a >> sh;
            4'd8: begin sx = {{32{a[31]}}, a} >> sh; res = sx[31:0]; end
            4'd9: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd10: res = (a < b) ? 32'd1 : 32'd0;
            4'd11: res = b;
            default: res = 32'h0;
        endcase
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [3:0] op, input logic sa, input logic sw, input logic sr,
                         input logic [3:0] ar, input logic [3:0] ti, input logic we);
        rs1_data = a; rs2_data = r2; imm_ext = imm; alu_control = op;
        sel_aluB = sa; sel_wdata = sw; sel_wreg = sr;
        rd_ar = ar; rd_ti = ti; reg_write = we;
    endtask

    // Drive one vector, check combinational outputs, then the registered bundle after the edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] r2, input logic [31:0] imm,
                         input logic [3:0] op, input logic sa, input logic sw, input logic sr,
                         input logic [3:0] ar, input logic [3:0] ti, input logic we);
        logic [31:0] b, res;
        logic        cy;
        wb_exp_t     e, got;
        drive(a, r2, imm, op, sa, sw, sr, ar, ti, we);
        b = sa ? imm : r2;
        ref_alu(a, b, op, res, cy);
        e.wdata = sw ? imm : res;
        e.wreg  = sr ? ti : ar;
        e.we    = we;
        e.c     = cy;
        e.z     = (res == 32'h0);
        #1;
        check("alu_result", alu_result, res);
        check("alu_cout",   {31'h0, alu_cout}, {31'h0, cy});
        check("write_data", write_data, e.wdata);
        check("write_reg",  {28'h0, write_reg}, {28'h0, e.wreg});
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'h1, 32'h0);
        end else begin
            got = exp_q.pop_front();
            check("wb_reg",  {28'h0, wb_reg}, {28'h0, got.wreg});
            check("wb_data", wb_data, got.wdata);
            check("wb_we",   {31'h0, wb_we},  {31'h0, got.we});
            check("flag_c",  {31'h0, flag_c}, {31'h0, got.c});
            check("flag_z",  {31'h0, flag_z}, {31'h0, got.z});
        end
        @(negedge CLK);
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_wb_reg"},  {28'h0, wb_reg}, 32'h0);
        check({tag, "_wb_data"}, wb_data, 32'h0);
        check({tag, "_wb_we"},   {31'h0, wb_we},  32'h0);
        check({tag, "_flag_c"},  {31'h0, flag_c}, 32'h0);
        check({tag, "_flag_z"},  {31'h0, flag_z}, 32'h0);
    endtask

    initial begin
        RESET = 1'b0;
        drive(32'h1, 32'h2, 32'h3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5, 4'd6, 1'b1);
        #1;
        check_regs_zero("reset_state");
        @(posedge CLK);
        #1;
        check_regs_zero("reset_held");
        @(negedge CLK);
        RESET = 1'b1;

        // ADD wrap with carry
        apply(32'hFFFF_FFFF, 32'h1, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1);
        // SUB / SLT with immediate operand, SLTU
        apply(32'd5, 32'h0, 32'd7, 4'd1, 1'b1, 1'b0, 1'b0, 4'd4, 4'd8, 1'b1);
        apply(32'd5, 32'h0, 32'd7, 4'd9, 1'b1, 1'b0, 1'b0, 4'd4, 4'd8, 1'b0);
        apply(32'h8000_0000, 32'h1, 32'h0, 4'd10, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1);
        apply(32'd7, 32'd7, 32'h0, 4'd1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1);
        // Shifts: B=0x24 uses only B[4:0]=4
        apply(32'h0000_000F, 32'h24, 32'h0, 4'd6, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b1);
        apply(32'h8000_0000, 32'h24, 32'h0, 4'd8, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b1);
        apply(32'h8000_0000, 32'h24, 32'h0, 4'd7, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 1'b1);
        // T/I writeback
        apply(32'h1234_5678, 32'h0, 32'hFFFC_0001, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9, 4'd3, 1'b1);
        // AR writeback with AND, then unused opcode
        apply(32'h0000_F0F0, 32'h0000_FF00, 32'h0, 4'd2, 1'b0, 1'b0, 1'b0, 4'd11, 4'd1, 1'b1);
        apply(32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 4'd13, 1'b0, 1'b0, 1'b0, 4'd11, 4'd1, 1'b0);
        // Remaining ops once each
        for (int k = 0; k < 16; k++) begin
            apply(32'hA5A5_3C3C, 32'h0F0F_00F3, 32'hFFFF_FFE1, 4'(k), 1'(k % 2), 1'b0, 1'(k % 3 == 0),
                  4'(k), 4'(15 - k), 1'(k % 2));
        end
        // Random vectors
        for (int k = 0; k < 60; k++) begin
            apply($urandom, $urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom),
                  1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end

        // Mid-cycle reset with nonzero registered outputs
        apply(32'h1, 32'h2, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd6, 1'b1);
        check("pre_reset_wb_data", wb_data, 32'h3);
        #2;
        RESET = 1'b0;
        #1;
        check_regs_zero("async_reset");
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK);
            #1;
            check_regs_zero("reset_low_edge");
        end
        @(negedge CLK);
        RESET = 1'b1;
        apply(32'h10, 32'h20, 32'h0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd6, 1'b1);
        check("post_reset_wb_data", wb_data, 32'h30);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
